// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-side arbiter.
package fifo_ctrl_pkg;

  localparam int N_REQ_DEFAULT      = 4;
  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int ADDR_WIDTH_DEFAULT = 5;
  localparam int DEPTH              = 2 ** ADDR_WIDTH_DEFAULT;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Pointer width that stays legal for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester / FIFO-write bundle between the requesters and the write arbiter.
interface fifo_write_arbiter_if
  import fifo_ctrl_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
);

  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0]            req_last;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            grant;
  logic [N_REQ-1:0]            accept;
  logic                        Wr_enable;
  logic [DATA_WIDTH-1:0]       wr_data;
  logic                        credit_return;
  logic [ADDR_WIDTH:0]         credits;
  logic                        busy;
  logic                        credit_err;

  modport master (
    output req, req_last, req_data, credit_return,
    input  grant, accept, Wr_enable, wr_data, credits, busy, credit_err
  );

  modport slave (
    input  req, req_last, req_data, credit_return,
    output grant, accept, Wr_enable, wr_data, credits, busy, credit_err
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or above rr_ptr, with wrap.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [N_REQ-1:0]   rot_winner;
  logic [2*N_REQ-1:0] unrotated;

  // Rotate so rr_ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign doubled    = {req, req} >> rr_ptr;
  assign rotated    = doubled[N_REQ-1:0];
  assign rot_winner = rotated & (~rotated + N_REQ'(1));
  assign unrotated  = {rot_winner, rot_winner} << rr_ptr;
  assign winner     = unrotated[2*N_REQ-1:N_REQ];
  assign valid      = |req;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Write-port scheduler: round-robin with packet locking, gated by a FIFO credit counter.
module fifo_write_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input logic                 write_clk,
  input logic                 reset,
  fifo_write_arbiter_if.slave bus
);

  localparam int                   PTR_W       = ptr_width(N_REQ);
  localparam int                   CREDIT_W    = ADDR_WIDTH + 1;
  localparam logic [CREDIT_W-1:0]  CREDIT_FULL = CREDIT_W'(2 ** ADDR_WIDTH);
  localparam logic [CREDIT_W-1:0]  CREDIT_ONE  = CREDIT_W'(1);
  localparam logic [PTR_W-1:0]     PTR_LAST    = PTR_W'(N_REQ - 1);

  state_t                 state, state_next;
  logic [N_REQ-1:0]       grant_q;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       owner_idx;
  logic [PTR_W-1:0]       next_ptr;
  logic [DATA_WIDTH-1:0]  owner_data;
  logic                   wr_en_q;
  logic [DATA_WIDTH-1:0]  wr_data_q;
  logic [CREDIT_W-1:0]    credits_q;
  logic                   credit_err_q;
  logic [N_REQ-1:0]       pick_winner;
  logic                   pick_valid;
  logic [N_REQ-1:0]       accept_vec;
  logic                   any_accept;
  logic                   accept_last;
  logic                   has_credit;
  logic                   busy;

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign has_credit  = (credits_q != '0);
  assign any_accept  = |accept_vec;
  assign accept_last = |(accept_vec & bus.req_last);
  assign next_ptr    = (owner_idx == PTR_LAST) ? '0 : owner_idx + PTR_W'(1);

  // NOTE: every variable driven from always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    owner_idx  = '0;
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx  = PTR_W'(i);
        owner_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge write_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (pick_valid && has_credit) state_next = LOCKED;
      LOCKED: if (accept_last)              state_next = IDLE;
    endcase
  end

  always_comb begin
    accept_vec = grant_q & bus.req & {N_REQ{has_credit}};
    busy       = (state == LOCKED);
  end

  always_ff @(posedge write_clk) begin
    if (reset) begin
      grant_q      <= '0;
      rr_ptr       <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      credits_q    <= CREDIT_FULL;
      credit_err_q <= 1'b0;
    end else begin
      wr_en_q <= any_accept;
      if (any_accept) wr_data_q <= owner_data;

      // Simultaneous accept and return cancel out; a return with nothing outstanding is an error.
      if (any_accept && !bus.credit_return) begin
        credits_q <= credits_q - CREDIT_ONE;
      end else if (!any_accept && bus.credit_return) begin
        if (credits_q == CREDIT_FULL) credit_err_q <= 1'b1;
        else                          credits_q    <= credits_q + CREDIT_ONE;
      end

      case (state)
        IDLE: if (pick_valid && has_credit) grant_q <= pick_winner;
        LOCKED: begin
          if (accept_last) begin
            grant_q <= '0;
            rr_ptr  <= next_ptr;
          end
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.accept     = accept_vec;
  assign bus.Wr_enable  = wr_en_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.credits    = credits_q;
  assign bus.busy       = busy;
  assign bus.credit_err = credit_err_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: vector table, corner sequences, randomized model run.
module tb_fifo_write_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  fifo_write_arbiter_if #(.N_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_write_arbiter #(.N_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .write_clk (clk),
    .reset     (reset),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic        cr;
    logic [3:0]  g;
    logic [3:0]  a;
    logic        wen;
    logic [7:0]  wd;
    logic [5:0]  cred;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    bus.req           = '0;
    bus.req_last      = '0;
    bus.req_data      = '0;
    bus.credit_return = 1'b0;
    advance();
    advance();
    reset = 1'b0;
  endtask

  // Behavioural reference: owner index (-1 = none), rotation pointer, free-entry count.
  int         m_owner;
  int         m_rr;
  int         m_credits;
  logic       m_err;
  logic       m_wen;
  logic [7:0] m_wd;

  function automatic bit bit_of(input logic [3:0] v, input int k);
    return ((v >> k) & 4'b0001) != 4'b0000;
  endfunction

  function automatic logic [3:0] onehot(input int k);
    return (k < 0) ? 4'b0000 : 4'(1 << k);
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_rr      = 0;
    m_credits = DEPTH;
    m_err     = 1'b0;
    m_wen     = 1'b0;
    m_wd      = 8'h00;
  endtask

  function automatic logic [3:0] model_accept();
    if (m_owner >= 0 && bit_of(bus.req, m_owner) && m_credits > 0) return onehot(m_owner);
    return 4'b0000;
  endfunction

  task automatic model_check();
    check("rand_grant",   32'(bus.grant),      32'(onehot(m_owner)));
    check("rand_accept",  32'(bus.accept),     32'(model_accept()));
    check("rand_wen",     32'(bus.Wr_enable),  32'(m_wen));
    check("rand_wdata",   32'(bus.wr_data),    32'(m_wd));
    check("rand_credits", 32'(bus.credits),    32'(m_credits));
    check("rand_busy",    32'(bus.busy),       32'(m_owner >= 0));
    check("rand_err",     32'(bus.credit_err), 32'(m_err));
  endtask

  task automatic model_update();
    logic [3:0]  acc;
    logic [31:0] sh;
    int          nc;
    int          k;
    acc = model_accept();
    if (reset) begin
      model_reset();
    end else begin
      nc = m_credits - ((acc != 0) ? 1 : 0) + (bus.credit_return ? 1 : 0);
      if (nc > DEPTH) begin
        nc    = DEPTH;
        m_err = 1'b1;
      end
      m_wen = (acc != 0);
      if (acc != 0) begin
        sh   = bus.req_data >> (8 * m_owner);
        m_wd = sh[7:0];
      end
      if (m_owner < 0) begin
        if (bus.req != 0 && m_credits > 0) begin
          for (int off = 0; off < NR; off++) begin
            k = (m_rr + off) % NR;
            if (m_owner < 0 && bit_of(bus.req, k)) m_owner = k;
          end
        end
      end else if (acc != 0 && bit_of(bus.req_last, m_owner)) begin
        m_rr    = (m_owner + 1) % NR;
        m_owner = -1;
      end
      m_credits = nc;
    end
  endtask

  initial begin
    int  n_wr;
    bit  found;

    n_checks = 0;
    n_errors = 0;

    // rst, req, last, data, cr | grant, accept, wen, wdata, credits, busy, err
    vecs[0]  = '{1'b0, 4'h1, 4'h1, 32'h0,         1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 6'd32, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'h1, 4'h1, 32'h0,         1'b0, 4'h1, 4'h1, 1'b0, 8'h00, 6'd32, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'h0, 4'h0, 32'h0,         1'b0, 4'h0, 4'h0, 1'b1, 8'h00, 6'd31, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'h0, 4'h0, 32'h0,         1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 6'd31, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'h0, 4'h0, 32'h0,         1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 6'd31, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'hF, 4'hF, 32'h13121110,  1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 6'd32, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'hF, 4'hF, 32'h13121110,  1'b0, 4'h1, 4'h1, 1'b0, 8'h00, 6'd32, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'hF, 4'hF, 32'h13121110,  1'b0, 4'h0, 4'h0, 1'b1, 8'h10, 6'd31, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'hF, 4'hF, 32'h13121110,  1'b0, 4'h2, 4'h2, 1'b0, 8'h10, 6'd31, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'hF, 4'hF, 32'h13121110,  1'b0, 4'h0, 4'h0, 1'b1, 8'h11, 6'd30, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'hF, 4'hF, 32'h13121110,  1'b0, 4'h4, 4'h4, 1'b0, 8'h11, 6'd30, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'hF, 4'hF, 32'h13121110,  1'b0, 4'h0, 4'h0, 1'b1, 8'h12, 6'd29, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'hF, 4'hF, 32'h13121110,  1'b0, 4'h8, 4'h8, 1'b0, 8'h12, 6'd29, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 4'hF, 4'hF, 32'h13121110,  1'b0, 4'h0, 4'h0, 1'b1, 8'h13, 6'd28, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'hF, 4'hF, 32'h13121110,  1'b0, 4'h1, 4'h1, 1'b0, 8'h13, 6'd28, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 4'h0, 4'h0, 32'h13121110,  1'b0, 4'h0, 4'h0, 1'b1, 8'h10, 6'd27, 1'b0, 1'b0};

    do_reset();

    for (int i = 0; i < 16; i++) begin
      reset             = vecs[i].rst;
      bus.req           = vecs[i].req;
      bus.req_last      = vecs[i].last;
      bus.req_data      = vecs[i].data;
      bus.credit_return = vecs[i].cr;
      settle();
      check($sformatf("vec%0d_grant", i),   32'(bus.grant),      32'(vecs[i].g));
      check($sformatf("vec%0d_accept", i),  32'(bus.accept),     32'(vecs[i].a));
      check($sformatf("vec%0d_wen", i),     32'(bus.Wr_enable),  32'(vecs[i].wen));
      check($sformatf("vec%0d_wdata", i),   32'(bus.wr_data),    32'(vecs[i].wd));
      check($sformatf("vec%0d_credits", i), 32'(bus.credits),    32'(vecs[i].cred));
      check($sformatf("vec%0d_busy", i),    32'(bus.busy),       32'(vecs[i].busy));
      check($sformatf("vec%0d_err", i),     32'(bus.credit_err), 32'(vecs[i].err));
      advance();
    end
    reset = 1'b0;

    // Packet lock: requester 0 pauses mid-packet while requester 1 waits.
    do_reset();
    bus.req      = 4'b0011;
    bus.req_last = 4'b0010;
    bus.req_data = 32'h0000_B0A0;
    settle();
    check("lock_grant_idle", 32'(bus.grant), 32'h0);
    advance();
    settle();
    check("lock_grant0", 32'(bus.grant), 32'h1);
    check("lock_accept_a0", 32'(bus.accept), 32'h1);
    advance();
    bus.req_data = 32'h0000_B0A1;
    settle();
    check("lock_wen_a0", 32'(bus.Wr_enable), 32'h1);
    check("lock_wd_a0", 32'(bus.wr_data), 32'hA0);
    check("lock_accept_a1", 32'(bus.accept), 32'h1);
    advance();
    bus.req = 4'b0010;
    settle();
    check("lock_wd_a1", 32'(bus.wr_data), 32'hA1);
    check("lock_gap1_grant", 32'(bus.grant), 32'h1);
    check("lock_gap1_accept", 32'(bus.accept), 32'h0);
    advance();
    settle();
    check("lock_gap2_grant", 32'(bus.grant), 32'h1);
    check("lock_gap2_accept", 32'(bus.accept), 32'h0);
    check("lock_gap2_wen", 32'(bus.Wr_enable), 32'h0);
    advance();
    bus.req      = 4'b0011;
    bus.req_last = 4'b0011;
    bus.req_data = 32'h0000_B0A2;
    settle();
    check("lock_accept_a2", 32'(bus.accept), 32'h1);
    advance();
    settle();
    check("lock_wd_a2", 32'(bus.wr_data), 32'hA2);
    check("lock_wen_a2", 32'(bus.Wr_enable), 32'h1);
    check("lock_bubble", 32'(bus.grant), 32'h0);
    advance();
    settle();
    check("lock_grant1", 32'(bus.grant), 32'h2);
    advance();
    settle();
    check("lock_wd_b0", 32'(bus.wr_data), 32'hB0);

    // Credit exhaustion and a single replenish.
    do_reset();
    bus.req      = 4'b0001;
    bus.req_last = 4'b0001;
    n_wr = 0;
    for (int i = 0; i < 70; i++) begin
      settle();
      if (bus.Wr_enable) n_wr++;
      bus.req_data = 32'(n_wr);
      advance();
    end
    check("exhaust_writes", 32'(n_wr), 32'd32);
    settle();
    check("exhaust_credits", 32'(bus.credits), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("exhaust_accept", 32'(bus.accept), 32'h0);
      check("exhaust_wen", 32'(bus.Wr_enable), 32'h0);
      advance();
      settle();
    end
    bus.credit_return = 1'b1;
    advance();
    bus.credit_return = 1'b0;
    n_wr = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      if (bus.Wr_enable) n_wr++;
      advance();
    end
    check("replenish_writes", 32'(n_wr), 32'd1);
    settle();
    check("replenish_credits", 32'(bus.credits), 32'd0);

    // Accept coincident with credit_return at credits=20.
    do_reset();
    bus.req      = 4'b0001;
    bus.req_last = 4'b0001;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      settle();
      if (bus.credits == 6'd20 && bus.accept != 4'b0000) begin
        found             = 1'b1;
        bus.credit_return = 1'b1;
      end
      advance();
    end
    bus.credit_return = 1'b0;
    bus.req           = 4'b0000;
    check("coincide_reached", 32'(found), 32'h1);
    settle();
    check("coincide_credits", 32'(bus.credits), 32'd20);
    check("coincide_wen", 32'(bus.Wr_enable), 32'h1);

    // Spurious return at full credit sets a sticky error.
    do_reset();
    settle();
    check("err_clear", 32'(bus.credit_err), 32'h0);
    bus.credit_return = 1'b1;
    advance();
    bus.credit_return = 1'b0;
    settle();
    check("err_credits", 32'(bus.credits), 32'd32);
    check("err_set", 32'(bus.credit_err), 32'h1);
    advance();
    advance();
    advance();
    settle();
    check("err_sticky", 32'(bus.credit_err), 32'h1);

    // Reset mid-packet with rr_ptr advanced past 0.
    advance();
    bus.req      = 4'b0100;
    bus.req_last = 4'b0100;
    bus.req_data = 32'h00C5_0000;
    advance();
    advance();
    bus.req_last = 4'b0000;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      settle();
      if (bus.credits == 6'd10 && bus.busy) found = 1'b1;
      else                                   advance();
    end
    check("midrst_reached", 32'(found), 32'h1);
    reset = 1'b1;
    advance();
    reset = 1'b0;
    settle();
    check("midrst_grant", 32'(bus.grant), 32'h0);
    check("midrst_wen", 32'(bus.Wr_enable), 32'h0);
    check("midrst_credits", 32'(bus.credits), 32'd32);
    check("midrst_err", 32'(bus.credit_err), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    bus.req      = 4'b1111;
    bus.req_last = 4'b1111;
    advance();
    settle();
    check("midrst_rr_from0", 32'(bus.grant), 32'h1);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 500; i++) begin
      reset             = ($urandom_range(0, 99) == 0);
      bus.req           = 4'($urandom) | 4'($urandom);
      bus.req_last      = 4'($urandom) & 4'($urandom);
      bus.req_data      = $urandom;
      bus.credit_return = ($urandom_range(0, 2) == 0);
      settle();
      model_check();
      model_update();
      advance();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Write-side scheduler for the dual-clock FIFO (default depth 32, 8-bit data). Shares the FIFO write port among N_REQ requesters.
- Round-robin arbitration with packet locking. A requester keeps the port until it writes a word flagged last.
- Runs entirely in the write_clk domain.
- Tracks free FIFO space with a credit counter, replenished by a read-pop pulse already synchronised into write_clk. It never writes the FIFO when full.

Parameters:
- N_REQ, 4, number of requesters.
- DATA_WIDTH, 8, word width; matches the FIFO data width.
- ADDR_WIDTH, 5, FIFO address width; DEPTH = 2**ADDR_WIDTH = 32 credits.

Ports:
- write_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- req  in  N_REQ  requester i has a word valid.
- req_last  in  N_REQ  word from requester i is the last of its packet.
- req_data  in  N_REQ*DATA_WIDTH  packed; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- grant  out  N_REQ  registered one-hot owner of the write port; all-zero when none.
- accept  out  N_REQ  combinational: grant[i] & req[i] & (credits!=0); the word transfers this cycle.
- Wr_enable  out  1  registered FIFO write strobe.
- wr_data  out  DATA_WIDTH  registered FIFO write data.
- credit_return  in  1  one pulse per word popped by the reader (write_clk domain).
- credits  out  ADDR_WIDTH+1  free FIFO entries, 0..DEPTH.
- busy  out  1  high while in LOCKED.
- credit_err  out  1  sticky; a credit_return arrived while credits==DEPTH.

Behaviour:
- Reset values: grant=0, Wr_enable=0, wr_data=0, credits=DEPTH, busy=0, credit_err=0, state=IDLE, rr_ptr=0.
- Reset asserted mid-packet aborts the packet with no further writes. The packet is not resumed.
- State IDLE:
  - If any req and credits!=0: pick the first requester with req set, searching from rr_ptr upward with wrap.
  - Register grant=onehot(winner) and go to LOCKED. Grant is visible the cycle after req is seen.
  - Otherwise stay in IDLE with grant=0.
- State LOCKED (owner k):
  - grant[k] is held. Only accept[k] may be high; accept for every other requester is 0.
  - On accept[k]: next cycle Wr_enable=1 and wr_data=req_data[k] (write latency 1 cycle after accept).
  - On accept[k] with req_last[k]: next state IDLE, rr_ptr=(k+1) mod N_REQ, grant=0 next cycle. There is one bubble cycle between packets.
  - req[k] low while LOCKED: no transfer, grant held. A requester may pause mid-packet.
  - credits==0 while LOCKED: stall (accept=0, Wr_enable=0), grant held.
- Wr_enable is 0 in every cycle not immediately following an accept. wr_data holds its last value when Wr_enable=0.
- Credit update: credits_next = credits - (|accept) + credit_return.
  - Accept and credit_return in the same cycle: credits unchanged.
  - credit_return with credits==DEPTH and no accept: credits stays DEPTH and credit_err is set.
  - credits never underflows, because accept is gated by credits!=0.
- Round-robin fairness: with all N_REQ requesting single-word packets continuously, ownership rotates 0,1,..,N_REQ-1,0.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - state encoding (IDLE, LOCKED);
  - localparam DEPTH = 2**ADDR_WIDTH;
  - default N_REQ and DATA_WIDTH.
- One sub-module, rr_picker: combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot winner and a valid flag.
- The FSM, credit counter and output registers stay in fifo_write_arbiter.

Test Plan:
- Reset 2 cycles. Then req[0]=1, req_last[0]=1, data 0x00.
  - Required: grant=0001 on the next cycle; accept[0]=1; Wr_enable=1 with wr_data=0x00 one cycle later.
  - Required: credits 32->31, then state IDLE.
- All 4 requesters hold single-word packets with data 0x10, 0x11, 0x12, 0x13.
  - Required: wr_data sequence 0x10, 0x11, 0x12, 0x13, 0x10.
  - Required: grant order 0,1,2,3,0 with one bubble between packets.
- req0 sends a 3-word packet (0xA0, 0xA1, 0xA2 with last); req1 is asserted throughout; req0 drops req for 2 cycles after 0xA1.
  - Required: grant[0] is held during the gap, and 0xA2 is written before any req1 word.
- 32 single-word writes with credit_return=0.
  - Required: credits=0, accept=0 and Wr_enable=0 while req is held.
  - Then one credit_return pulse: required exactly one further write, with credits back to 0.
- Accept coincident with credit_return at credits=20: required credits stays 20.
- At credits=32 with no accept, pulse credit_return: required credits=32 and credit_err=1 and sticky.
- Assert reset mid-packet while LOCKED with credits=10.
  - Required next cycle: grant=0, Wr_enable=0, credits=32, credit_err=0, busy=0.
  - Required: the next arbitration starts from requester 0.
